// File: rtl/sd_pkg.sv
// Shared constants, state type and CRC16 step for the SD SPI data path.
// Used by both the block receiver and the later CMD24 write path.
package sd_pkg;

    localparam logic [7:0]  SD_DATA_TOKEN = 8'hFE;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        DATA,
        CRC,
        DONE
    } sd_rx_state_t;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] c,
        input logic        d
    );
        logic fb;
        fb = d ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_block_rx_if.sv
// Control, serial and buffer-read signals of the SD block receiver.
// master = command engine / consumer side, slave = receiver.
interface sd_block_rx_if #(
    parameter int BLOCK_BYTES = 512
) ();

    localparam int AW = $clog2(BLOCK_BYTES);

    logic          start;
    logic          sample_en;
    logic          sd_data0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic          timeout;

    modport master (
        output start,
        output sample_en,
        output sd_data0,
        output rd_addr,
        input  rd_data,
        input  busy,
        input  done,
        input  crc_ok,
        input  timeout
    );

    modport slave (
        input  start,
        input  sample_en,
        input  sd_data0,
        input  rd_addr,
        output rd_data,
        output busy,
        output done,
        output crc_ok,
        output timeout
    );

endinterface

// File: rtl/sd_crc16.sv
// Bit-serial CRC16 (x^16+x^12+x^5+1), init 0, no reflection.
// Shared between the read and write data paths.
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_block_rx.sv
// SPI-mode SD single-block receiver: token hunt, data capture
// into an on-chip buffer, CRC16 check, done/timeout reporting.
module sd_block_rx
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES   = 512,
    parameter int TOKEN_TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    sd_block_rx_if.slave  bus
);

    localparam int AW = $clog2(BLOCK_BYTES);
    localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
    localparam logic [AW:0]   LAST_BYTE = (AW+1)'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TOKEN_TIMEOUT - 1);

    sd_rx_state_t state;

    logic [7:0]    win;
    logic [7:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [AW:0]   byte_cnt;
    logic [TW-1:0] to_cnt;
    logic [15:0]   rx_crc;
    logic [15:0]   calc_crc;
    logic          busy_q;
    logic          done_q;
    logic          crc_ok_q;
    logic          timeout_q;
    logic [7:0]    rd_q;
    logic [7:0]    mem [BLOCK_BYTES];

    logic          go;
    logic          crc_en;
    logic          wr_en;
    logic [7:0]    win_nx;
    logic [7:0]    byte_nx;
    logic [15:0]   rx_nx;

    assign go      = (state == IDLE) && bus.start;
    assign crc_en  = (state == DATA) && bus.sample_en;
    assign wr_en   = crc_en && (bit_cnt == 4'd7);
    assign win_nx  = {win[6:0], bus.sd_data0};
    assign byte_nx = {shreg[6:0], bus.sd_data0};
    assign rx_nx   = {rx_crc[14:0], bus.sd_data0};

    sd_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .en    (crc_en),
        .din   (bus.sd_data0),
        .crc   (calc_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win       <= 8'hFF;
            shreg     <= 8'h00;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            rx_crc    <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // a strobe coinciding with start is dropped here
                    if (bus.start) begin
                        state     <= HUNT;
                        busy_q    <= 1'b1;
                        crc_ok_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        rx_crc    <= 16'h0000;
                        byte_cnt  <= '0;
                        bit_cnt   <= '0;
                        to_cnt    <= '0;
                        win       <= 8'hFF;
                    end
                end
                HUNT: begin
                    if (bus.sample_en) begin
                        win <= win_nx;
                        if (win_nx == SD_DATA_TOKEN) begin
                            state <= DATA;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                            if (to_cnt == TO_LAST) begin
                                state     <= DONE;
                                done_q    <= 1'b1;
                                busy_q    <= 1'b0;
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (bus.sample_en) begin
                        shreg   <= byte_nx;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == LAST_BYTE) begin
                                state <= CRC;
                            end
                        end
                    end
                end
                CRC: begin
                    if (bus.sample_en) begin
                        rx_crc  <= rx_nx;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            crc_ok_q <= (rx_nx == calc_crc);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // buffer is plain RAM: no reset, written on the 8th bit's strobe
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[byte_cnt[AW-1:0]] <= byte_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= 8'h00;
        end else begin
            rd_q <= mem[bus.rd_addr];
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.crc_ok  = crc_ok_q;
    assign bus.timeout = timeout_q;

endmodule
